// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Holds one NxN A matrix and one NxN B matrix and, on start, drives the
//   skewed west (A rows) and north (B columns) operand streams of an NxN
//   multiply-accumulate array: one clear cycle, 2N-1 feed cycles, N-1 zero
//   flush cycles, then a one-cycle done pulse.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   wr_valid/wr_ready   : element write handshake (ready only when idle)
//   wr_sel              : 0 = A buffer, 1 = B buffer
//   wr_row, wr_col      : element position
//   wr_data             : element value
//   start               : begin a run (honoured only when idle)
//   busy                : high during clear/feed/flush
//   done                : one-cycle pulse after the last flush cycle
//   pe_clear            : clears every PE accumulator
//   a_out               : slice i feeds PE row i, column 0
//   b_out               : slice j feeds PE row 0, column j
//   feed_valid          : high during feed and flush
module systolic_feeder #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 wr_sel,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [$clog2(N)-1:0] wr_col,
  input  logic [DW-1:0]        wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pe_clear,
  output logic [N*DW-1:0]      a_out,
  output logic [N*DW-1:0]      b_out,
  output logic                 feed_valid
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(2 * N);
  localparam logic [TW-1:0] T_FEED_LAST  = TW'(2 * N - 2);
  localparam logic [TW-1:0] T_FLUSH_LAST = TW'(N - 2);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   t_q;
  logic [DW-1:0]   a_buf_q [N][N];
  logic [DW-1:0]   b_buf_q [N][N];
  logic [N*DW-1:0] a_out_q, b_out_q;
  logic            wr_ready_q, busy_q, done_q, pe_clear_q, feed_valid_q;

  // Operand slices for the feed step that will be presented next cycle.
  logic [TW-1:0]   t_d;
  logic [TW-1:0]   k;
  logic [N*DW-1:0] a_out_d, b_out_d;

  always_comb begin
    t_d     = (state_q == FEED) ? t_q + TW'(1) : '0;
    k       = '0;
    a_out_d = '0;
    b_out_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = t_d - TW'(i);
      // Row/column i enters i cycles late and stays for exactly N cycles.
      if (t_d >= TW'(i) && k < TW'(N)) begin
        a_out_d[i*DW +: DW] = a_buf_q[i][k[IW-1:0]];
        b_out_d[i*DW +: DW] = b_buf_q[k[IW-1:0]][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < N; r++) begin
        for (int unsigned c = 0; c < N; c++) begin
          a_buf_q[r][c] <= '0;
          b_buf_q[r][c] <= '0;
        end
      end
    end else if (wr_ready_q && wr_valid) begin
      if (wr_sel) b_buf_q[wr_row][wr_col] <= wr_data;
      else        a_buf_q[wr_row][wr_col] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      t_q          <= '0;
      a_out_q      <= '0;
      b_out_q      <= '0;
      wr_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pe_clear_q   <= 1'b0;
      feed_valid_q <= 1'b0;
    end else begin
      pe_clear_q <= 1'b0;
      done_q     <= 1'b0;
      a_out_q    <= '0;
      b_out_q    <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= CLEAR;
            pe_clear_q <= 1'b1;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
          end
        end
        CLEAR: begin
          state_q      <= FEED;
          t_q          <= '0;
          feed_valid_q <= 1'b1;
          a_out_q      <= a_out_d;
          b_out_q      <= b_out_d;
        end
        FEED: begin
          if (t_q == T_FEED_LAST) begin
            state_q <= FLUSH;
            t_q     <= '0;
          end else begin
            t_q     <= t_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
          end
        end
        FLUSH: begin
          if (t_q == T_FLUSH_LAST) begin
            state_q      <= IDLE;
            t_q          <= '0;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            feed_valid_q <= 1'b0;
            wr_ready_q   <= 1'b1;
          end else begin
            t_q <= t_q + TW'(1);
          end
        end
        default: begin
          state_q      <= IDLE;
          t_q          <= '0;
          busy_q       <= 1'b0;
          feed_valid_q <= 1'b0;
          wr_ready_q   <= 1'b1;
        end
      endcase
    end
  end

  assign wr_ready   = wr_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pe_clear   = pe_clear_q;
  assign a_out      = a_out_q;
  assign b_out      = b_out_q;
  assign feed_valid = feed_valid_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder
//   Randomised and directed bench for systolic_feeder (N=4, DW=8). A matrix
//   model predicts the skewed streams from the run schedule, and an attached
//   PE-array model's accumulators are compared against the matrix product.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int RUN_LEN = 3 * N - 1;

  logic            clk = 1'b0;
  logic            reset, wr_valid, wr_sel, start;
  logic [1:0]      wr_row, wr_col;
  logic [DW-1:0]   wr_data;
  logic            wr_ready, busy, done, pe_clear, feed_valid;
  logic [N*DW-1:0] a_out, b_out;

  systolic_feeder #(.N(N), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_sel     (wr_sel),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pe_clear   (pe_clear),
    .a_out      (a_out),
    .b_out      (b_out),
    .feed_valid (feed_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ma [N][N];
  int mb [N][N];

  // PE array model: a moves east, b moves south, each PE accumulates a*b.
  logic [DW-1:0] pa  [N][N];
  logic [DW-1:0] pb  [N][N];
  logic [DW-1:0] acc [N][N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [DW-1:0] ina, inb;
        ina = (j == 0) ? a_out[i*DW +: DW] : pa[i][j-1];
        inb = (i == 0) ? b_out[j*DW +: DW] : pb[i-1][j];
        if (reset || pe_clear) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j]  <= ina;
          pb[i][j]  <= inb;
          acc[i][j] <= acc[i][j] + DW'(ina * inb);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] exp_a(input int t);
    logic [N*DW-1:0] r = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) r[i*DW +: DW] = DW'(ma[i][t-i]);
    return r;
  endfunction

  function automatic logic [N*DW-1:0] exp_b(input int t);
    logic [N*DW-1:0] r = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) r[j*DW +: DW] = DW'(mb[t-j][j]);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_el(input bit sel, input int r, input int c, input int d);
    wr_valid = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = DW'(d);
    check("wr_ready_idle", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    if (sel) mb[r][c] = d & 8'hFF; else ma[r][c] = d & 8'hFF;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_a"}, a_out, 0);
    check({tag, "_b"}, b_out, 0);
    check({tag, "_clr"}, pe_clear, 0);
    check({tag, "_fv"}, feed_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rdy"}, wr_ready, 1);
  endtask

  task automatic check_pe();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
        check($sformatf("pe_%0d_%0d", i, j), acc[i][j], s & 8'hFF);
      end
  endtask

  // Caller drives start=1 just after a rising edge. Sample m is taken just
  // after the m-th edge following the start edge: m=0 clear, m=1..2N-1 feed,
  // m=2N..3N-2 flush, m=3N-1 done.
  task automatic do_run(input bit chain, input int poke_m, input int abort_m);
    int first_done = -1;
    step();
    start = 1'b0; wr_valid = 1'b0;
    for (int m = 0; m <= RUN_LEN; m++) begin
      bit infeed = (m >= 1 && m <= 2 * N - 1);
      check("a_out", a_out, infeed ? exp_a(m - 1) : '0);
      check("b_out", b_out, infeed ? exp_b(m - 1) : '0);
      check("pe_clear", pe_clear, m == 0);
      check("feed_valid", feed_valid, m >= 1 && m <= RUN_LEN - 1);
      check("busy", busy, m <= RUN_LEN - 1);
      check("wr_ready", wr_ready, m == RUN_LEN);
      if (done && first_done < 0) first_done = m;
      if (m == abort_m) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin ma[i][j] = 0; mb[i][j] = 0; end
        check_idle("abort");
        for (int c = 0; c < RUN_LEN + 2; c++) begin
          step();
          check("no_done", done, 0);
        end
        return;
      end
      if (m == poke_m) begin
        wr_valid = 1'b1; wr_sel = 1'($urandom); wr_row = 2'($urandom);
        wr_col = 2'($urandom); wr_data = DW'($urandom); start = 1'b1;
      end
      if (m == RUN_LEN && chain) start = 1'b1;
      if (m < RUN_LEN) begin
        step();
        wr_valid = 1'b0; start = 1'b0;
      end
    end
    check("done_latency", first_done, RUN_LEN);
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
    wr_data = '0; start = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin ma[i][j] = 0; mb[i][j] = 0; end
    step(); step();
    reset = 1'b0;
    check_idle("reset");

    // A = 1..16, B = identity
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        write_el(0, i, j, i * N + j + 1);
        write_el(1, i, j, (i == j) ? 1 : 0);
      end
    start = 1'b1;
    do_run(0, -1, -1);
    check_pe();

    // B = A, so the array computes A*A
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) write_el(1, i, j, ma[i][j]);
    start = 1'b1;
    do_run(0, -1, -1);
    check_pe();
    check("pe00_aa", acc[0][0], 90);

    // write + start while busy: ignored, then replay must see same matrices
    start = 1'b1;
    do_run(0, 3, -1);
    check_pe();
    start = 1'b1;
    do_run(0, -1, -1);
    check_pe();

    // write accepted in the start cycle is used by that run
    wr_valid = 1'b1; wr_sel = 1'b0; wr_row = 2'd2; wr_col = 2'd1;
    wr_data = 8'hFF; start = 1'b1;
    ma[2][1] = 255;
    do_run(0, -1, -1);
    check_pe();

    // back-to-back: start in the done cycle
    start = 1'b1;
    do_run(1, -1, -1);
    do_run(0, -1, -1);
    check_pe();

    // random matrices
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          write_el(0, i, j, int'($urandom_range(255)));
          write_el(1, i, j, int'($urandom_range(255)));
        end
      start = 1'b1;
      do_run(0, -1, -1);
      check_pe();
    end

    // reset at FEED t=2 aborts and zeroes buffers; next run streams zeros
    start = 1'b1;
    do_run(0, -1, 3);
    start = 1'b1;
    do_run(0, -1, -1);
    check_pe();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
